// File: rtl/hex_page_sequencer_pkg.sv
// Shared types and sizes for the HEX page sequencer.
package hex_page_sequencer_pkg;

  localparam int unsigned REQ_N  = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned PTR_W  = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShow  = 2'd1,
    StBlank = 2'd2
  } state_e;

endpackage

// File: rtl/hex_page_sequencer_rr_arbiter4.sv
// Combinational round-robin pick among four requesters, starting the scan at i_ptr.
module hex_page_sequencer_rr_arbiter4
  import hex_page_sequencer_pkg::*;
(
  input  logic [REQ_N-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [PTR_W-1:0] o_win,
  output logic             o_any
);

  logic [PTR_W-1:0] w_idx;

  // Scan from farthest to nearest so the requester closest to i_ptr wins last.
  always_comb begin
    o_win = '0;
    o_any = 1'b0;
    w_idx = '0;
    for (int k = REQ_N - 1; k >= 0; k--) begin
      w_idx = i_ptr + PTR_W'(k);
      if (i_req[w_idx]) begin
        o_win = w_idx;
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hex_page_sequencer.sv
// Time-shares one two-digit HEX display between four requesters with a guaranteed dwell.
// Optional blank gap between pages is enabled by defining HEXSEQ_BLANK_EN.
module hex_page_sequencer
  import hex_page_sequencer_pkg::*;
#(
  parameter int unsigned DWELL        = 50_000_000,
  parameter int unsigned CNT_W        = 26,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [REQ_N-1:0]  i_req,
  input  logic [DATA_W-1:0] i_data0,
  input  logic [DATA_W-1:0] i_data1,
  input  logic [DATA_W-1:0] i_data2,
  input  logic [DATA_W-1:0] i_data3,
  input  logic              i_hold,
  output logic [REQ_N-1:0]  o_grant,
  output logic [PTR_W-1:0]  o_sel,
  output logic [DATA_W-1:0] o_disp_data,
  output logic              o_disp_blank,
  output logic              o_busy,
  output logic              o_page_done
);

  localparam logic [CNT_W-1:0] DWELL_INIT = CNT_W'(DWELL - 1);
  localparam int unsigned      CNT_MAX    = (DWELL > BLANK_CYCLES) ? DWELL : BLANK_CYCLES;

  if (DWELL == 0 || ((CNT_MAX - 1) >> CNT_W) != 0) begin : g_bad_cnt_w
    $error("hex_page_sequencer: DWELL must be >= 1 and fit in CNT_W");
  end

  state_e            r_state, w_state_d;
  logic [PTR_W-1:0]  r_ptr, w_ptr_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;
  logic [REQ_N-1:0]  r_grant, w_grant_d;
  logic [PTR_W-1:0]  r_sel, w_sel_d;
  logic [DATA_W-1:0] r_disp_data, w_disp_data_d;
  logic              r_busy, w_busy_d;
  logic              r_page_done, w_page_done_d;

  logic [DATA_W-1:0] w_data [REQ_N];
  logic [PTR_W-1:0]  w_arb_ptr;
  logic [PTR_W-1:0]  w_win;
  logic              w_any;
  logic              w_grant_now;

  assign w_data[0] = i_data0;
  assign w_data[1] = i_data1;
  assign w_data[2] = i_data2;
  assign w_data[3] = i_data3;

  // On dwell expiry the scan must already start past the page just shown.
  assign w_arb_ptr = (r_state == StShow) ? r_sel + PTR_W'(1) : r_ptr;

  hex_page_sequencer_rr_arbiter4 u_arb (
    .i_req (i_req),
    .i_ptr (w_arb_ptr),
    .o_win (w_win),
    .o_any (w_any)
  );

`ifdef HEXSEQ_BLANK_EN
  localparam logic [CNT_W-1:0] BLANK_INIT = CNT_W'(BLANK_CYCLES - 1);
  logic r_disp_blank, w_disp_blank_d;
`endif

  always_comb begin
    w_state_d     = r_state;
    w_ptr_d       = r_ptr;
    w_cnt_d       = r_cnt;
    w_grant_d     = r_grant;
    w_sel_d       = r_sel;
    w_disp_data_d = r_disp_data;
    w_busy_d      = r_busy;
    w_page_done_d = 1'b0;
    w_grant_now   = 1'b0;
`ifdef HEXSEQ_BLANK_EN
    w_disp_blank_d = r_disp_blank;
`endif
    unique case (r_state)
      StIdle: w_grant_now = w_any && !i_hold;
      StShow: begin
        if (!i_hold) begin
          if (r_cnt != '0) begin
            w_cnt_d = r_cnt - CNT_W'(1);
          end else begin
            w_page_done_d = 1'b1;
            w_ptr_d       = r_sel + PTR_W'(1);
            w_grant_d     = '0;
`ifdef HEXSEQ_BLANK_EN
            w_state_d      = StBlank;
            w_disp_blank_d = 1'b1;
            w_cnt_d        = BLANK_INIT;
`else
            w_grant_now = w_any;
            w_state_d   = StIdle;
            w_busy_d    = 1'b0;
`endif
          end
        end
      end
`ifdef HEXSEQ_BLANK_EN
      StBlank: begin
        if (r_cnt == '0) begin
          w_disp_blank_d = 1'b0;
          w_grant_now    = w_any && !i_hold;
          w_state_d      = StIdle;
          w_busy_d       = 1'b0;
        end else if (!i_hold) begin
          w_cnt_d = r_cnt - CNT_W'(1);
        end
      end
`endif
      default: w_state_d = StIdle;
    endcase
    // A grant overrides any idle/blank decision made above in the same cycle.
    if (w_grant_now) begin
      w_state_d     = StShow;
      w_grant_d     = REQ_N'(1) << w_win;
      w_sel_d       = w_win;
      w_disp_data_d = w_data[w_win];
      w_busy_d      = 1'b1;
      w_cnt_d       = DWELL_INIT;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_grant     <= '0;
      r_sel       <= '0;
      r_disp_data <= '0;
      r_busy      <= 1'b0;
      r_page_done <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_ptr       <= w_ptr_d;
      r_cnt       <= w_cnt_d;
      r_grant     <= w_grant_d;
      r_sel       <= w_sel_d;
      r_disp_data <= w_disp_data_d;
      r_busy      <= w_busy_d;
      r_page_done <= w_page_done_d;
    end
  end

`ifdef HEXSEQ_BLANK_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_disp_blank <= 1'b0;
    else          r_disp_blank <= w_disp_blank_d;
  end
  assign o_disp_blank = r_disp_blank;
`else
  assign o_disp_blank = 1'b0;
`endif

  assign o_grant     = r_grant;
  assign o_sel       = r_sel;
  assign o_disp_data = r_disp_data;
  assign o_busy      = r_busy;
  assign o_page_done = r_page_done;

endmodule

// File: tb/tb_hex_page_sequencer.sv
// Self-checking bench for hex_page_sequencer: vector table, directed corners, random vs model.
module tb_hex_page_sequencer;

  localparam int unsigned DWELL = 4;
  localparam int unsigned BLANK = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic       hold = 1'b0;
  logic [7:0] dat [4];
  logic [3:0] grant;
  logic [1:0] sel;
  logic [7:0] disp;
  logic       dblank, busy, pd;

  always #5 clk = ~clk;

  hex_page_sequencer #(
    .DWELL        (DWELL),
    .CNT_W        (26),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req        (req),
    .i_data0      (dat[0]),
    .i_data1      (dat[1]),
    .i_data2      (dat[2]),
    .i_data3      (dat[3]),
    .i_hold       (hold),
    .o_grant      (grant),
    .o_sel        (sel),
    .o_disp_data  (disp),
    .o_disp_blank (dblank),
    .o_busy       (busy),
    .o_page_done  (pd)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Reference model: page owner and cycles remaining, computed from the rules directly.
  int         m_owner, m_left, m_ptr, m_sel;
  bit         m_blank, m_pd;
  logic [7:0] m_data;

  function automatic int pick(logic [3:0] r, int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_left = 0; m_ptr = 0; m_sel = 0;
    m_blank = 0; m_pd = 0; m_data = '0;
  endtask

  task automatic model_grant(int w);
    m_owner = w; m_sel = w; m_data = dat[w]; m_left = DWELL;
  endtask

  task automatic model_step();
    m_pd = 0;
    if (m_blank) begin
      if (m_left > 1) begin
        if (!hold) m_left--;
      end else begin
        m_blank = 0;
        if (req != 0 && !hold) model_grant(pick(req, m_ptr));
      end
    end else if (m_owner >= 0) begin
      if (!hold) begin
        if (m_left > 1) m_left--;
        else begin
          m_pd = 1;
          m_ptr = (m_sel + 1) % 4;
          m_owner = -1;
`ifdef HEXSEQ_BLANK_EN
          m_blank = 1;
          m_left = BLANK;
`else
          if (req != 0) model_grant(pick(req, m_ptr));
`endif
        end
      end
    end else if (req != 0 && !hold) begin
      model_grant(pick(req, m_ptr));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk_model(int cyc);
    logic [3:0] eg;
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'h0;
    chk($sformatf("rnd%0d.grant", cyc), grant, eg);
    chk($sformatf("rnd%0d.sel", cyc), sel, m_sel);
    chk($sformatf("rnd%0d.disp", cyc), disp, m_data);
    chk($sformatf("rnd%0d.busy", cyc), busy, (m_owner >= 0) || m_blank);
    chk($sformatf("rnd%0d.blank", cyc), dblank, m_blank);
    chk($sformatf("rnd%0d.done", cyc), pd, m_pd);
  endtask

  task automatic go_idle(string name);
    req = '0;
    hold = 1'b0;
    for (int i = 0; i < 40 && busy; i++) tick();
    if (busy) timeout(name);
  endtask

  typedef struct {
    logic [3:0] req;
    logic       hold;
    logic [3:0] grant;
    logic [1:0] sel;
    logic [7:0] data;
    logic       busy;
    logic       pd;
    logic       blank;
  } vec_t;

  vec_t tbl[$];
  logic [7:0] base [4];

  function automatic void add(logic [3:0] r, logic h, logic [3:0] g, logic [1:0] s,
                              logic [7:0] d, logic b, logic p, logic bl);
    tbl.push_back('{r, h, g, s, d, b, p, bl});
  endfunction

  initial begin
    int len, npd;
    base[0] = 8'h11; base[1] = 8'h22; base[2] = 8'h33; base[3] = 8'h44;
    for (int i = 0; i < 4; i++) dat[i] = base[i];

`ifndef HEXSEQ_BLANK_EN
    add(4'h0, 0, 4'h0, 0, 8'h00, 0, 0, 0);
    for (int p = 0; p < 5; p++)
      for (int c = 0; c < 4; c++)
        add(4'hF, 0, 4'(1 << (p % 4)), 2'(p % 4), base[p % 4], 1, (c == 0 && p > 0), 0);
    add(4'h0, 0, 4'h0, 0, 8'h11, 0, 1, 0);
    add(4'h1, 1, 4'h0, 0, 8'h11, 0, 0, 0);
    add(4'h1, 1, 4'h0, 0, 8'h11, 0, 0, 0);
    add(4'h1, 0, 4'h1, 0, 8'h11, 1, 0, 0);
    for (int c = 0; c < 3; c++) add(4'h0, 0, 4'h1, 0, 8'h11, 1, 0, 0);
    add(4'h0, 0, 4'h0, 0, 8'h11, 0, 1, 0);
`else
    add(4'h0, 0, 4'h0, 0, 8'h00, 0, 0, 0);
    for (int c = 0; c < 4; c++) add(4'h3, 0, 4'h1, 0, 8'h11, 1, 0, 0);
    for (int c = 0; c < 2; c++) add(4'h3, 0, 4'h0, 0, 8'h11, 1, (c == 0), 1);
    for (int c = 0; c < 4; c++) add(4'h3, 0, 4'h2, 1, 8'h22, 1, 0, 0);
    for (int c = 0; c < 2; c++) add(4'h3, 0, 4'h0, 1, 8'h22, 1, (c == 0), 1);
    add(4'h3, 0, 4'h1, 0, 8'h11, 1, 0, 0);
`endif

    // Reset values
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.grant", grant, 0);
    chk("rst.sel", sel, 0);
    chk("rst.disp", disp, 0);
    chk("rst.blank", dblank, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", pd, 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      req = tbl[i].req;
      hold = tbl[i].hold;
      tick();
      chk($sformatf("tbl%0d.grant", i), grant, tbl[i].grant);
      chk($sformatf("tbl%0d.sel", i), sel, tbl[i].sel);
      chk($sformatf("tbl%0d.disp", i), disp, tbl[i].data);
      chk($sformatf("tbl%0d.busy", i), busy, tbl[i].busy);
      chk($sformatf("tbl%0d.done", i), pd, tbl[i].pd);
      chk($sformatf("tbl%0d.blank", i), dblank, tbl[i].blank);
    end
    go_idle("tbl_idle");

    // One-cycle request pulse still gets a full dwell, then idles holding sel/data
    req = 4'b0100;
    tick();
    req = '0;
    len = 0; npd = 0;
    for (int i = 0; i < 30; i++) begin
      if (grant == 4'b0100) len++;
      if (pd) npd++;
      if (!busy) break;
      tick();
    end
    if (busy) timeout("pulse_idle");
    chk("pulse.len", len, DWELL);
    chk("pulse.done_cnt", npd, 1);
    chk("pulse.grant", grant, 0);
    chk("pulse.sel", sel, 2);
    chk("pulse.disp", disp, 8'h33);

    // Snapshot survives data change until the next grant
    go_idle("snap_idle");
    dat[1] = 8'hA5;
    req = 4'b0010;
    tick();
    chk("snap.first", disp, 8'hA5);
    dat[1] = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("snap.hold%0d", i), disp, 8'hA5);
    end
    for (int i = 0; i < 10 && !pd; i++) tick();
    if (!pd) timeout("snap_done");
    for (int i = 0; i < 10 && grant != 4'b0010; i++) tick();
    chk("snap.next", disp, 8'h5A);
    dat[1] = base[1];

    // Hold for 3 cycles mid-page stretches the dwell to 7
    go_idle("hold_idle");
    req = 4'b0010;
    tick();
    req = '0;
    len = 1;
    tick();
    if (grant == 4'b0010) len++;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (grant == 4'b0010) len++;
    end
    hold = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (grant != 4'b0010) break;
      len++;
    end
    chk("hold.len", len, DWELL + 3);

    // Hold in idle blocks the grant until released
    go_idle("hidle_idle");
    req = 4'b0001;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hidle.blocked%0d", i), grant, 0);
    end
    hold = 1'b0;
    tick();
    chk("hidle.grant", grant, 4'b0001);

    // Async reset mid-page returns everything, including ptr, to reset values
    go_idle("arst_idle");
    req = 4'b0010;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst.grant", grant, 0);
    chk("arst.sel", sel, 0);
    chk("arst.disp", disp, 0);
    chk("arst.busy", busy, 0);
    req = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("arst.regrant", grant, 4'b0001);
    chk("arst.regrant_data", disp, 8'h11);

    // Randomized traffic against the reference model
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      hold = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 7) == 0) dat[$urandom_range(0, 3)] = 8'($urandom);
      tick();
      chk_model(cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
